// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan scheduler.
//   state_e       : scheduler state (IDLE, BLANK, DRIVE)
//   NIBBLE_W      : width of one displayed digit value
//   next_enabled  : next set bit of an enable mask above idx, wrapping
// Optional feature macro used by the top level: SSEG_DIM_EN.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // Searches upward from idx+1 through the n active bits of en and wraps to
  // the bottom. Returns idx itself when no other digit is enabled. Passing
  // idx = n-1 therefore yields the lowest enabled digit.
  function automatic logic [2:0] next_enabled(input logic [2:0] idx,
                                              input logic [7:0] en,
                                              input int         n);
    logic [2:0] r;
    logic       found;
    int         cand;
    r     = idx;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !found) begin
        cand = (int'(idx) + k) % n;
        if (en[cand[2:0]]) begin
          r     = cand[2:0];
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Slot-timing counter for the scan scheduler.
//   clk, rst_n    : clock, synchronous active-low reset
//   clr_i         : force the count to 0 (has priority over en_i)
//   en_i          : advance the count, wrapping after PRESCALE-1
//   cnt_o         : current count within the slot
//   tc_o          : count is PRESCALE-1 (last cycle of the slot)
//   blank_done_o  : the next count is past the blank interval
module sseg_prescaler #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16,
  localparam int CNT_W       = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o,
  output logic             blank_done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt_o        = cnt_q;
  assign tc_o         = (cnt_q == CNT_W'(PRESCALE - 1));
  // Looks one cycle ahead so the registered anode turns on exactly when the
  // count reaches BLANK_CYCLES.
  assign blank_done_o = (cnt_q >= CNT_W'(BLANK_CYCLES - 1));

endmodule

// File: rtl/sseg_scan_scheduler.sv
// Seven-segment scan scheduler: steps through the enabled digits, one slot of
// PRESCALE cycles each, with all anodes off for the first BLANK_CYCLES of every
// slot. Display data is double-buffered and only committed at frame
// boundaries (slot advance onto the lowest enabled digit).
//   clk, rst_n   : clock, synchronous active-low reset
//   digit_en     : per-digit scan enable (all zero -> IDLE)
//   load         : strobe, captures load_data into the shadow buffer
//   load_data    : digit i value in bits [4i+3:4i]
//   load_ack     : pulse when the shadow is committed to the display register
//   digit_idx    : digit currently scheduled
//   anode_n      : active-low one-hot anode drive
//   nibble       : display-register value of digit_idx
//   frame_start  : pulse on the first slot of each frame
//   dim_level    : (SSEG_DIM_EN only) drive-window length, 7 = full
// All outputs are registered and reflect the next-state values computed below.
module sseg_scan_scheduler
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                       clk,
`ifdef SSEG_DIM_EN
  input  logic [2:0]                 dim_level,
`endif
  input  logic                       rst_n,
  input  logic [NUM_DIGITS-1:0]      digit_en,
  input  logic                       load,
  input  logic [4*NUM_DIGITS-1:0]    load_data,
  output logic                       load_ack,
  output logic [IDX_W-1:0]           digit_idx,
  output logic [NUM_DIGITS-1:0]      anode_n,
  output logic [NIBBLE_W-1:0]        nibble,
  output logic                       frame_start
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int DE_W  = CNT_W + 1;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_DIGITS-1:0]     anode_q, anode_d;
  logic [NIBBLE_W-1:0]       nibble_q, nibble_d;
  logic                      ack_q, ack_d;
  logic                      fs_q, fs_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
  logic                      pend_q, pend_d;

  logic [CNT_W-1:0]          cnt, p_next;
  logic                      tc, blank_done, clr;
  logic [7:0]                en8;
  logic [IDX_W-1:0]          lowest, nxt;
  logic                      boundary;
  logic [DE_W-1:0]           drive_end;

  assign en8    = 8'(digit_en);
  assign lowest = IDX_W'(next_enabled(3'(NUM_DIGITS - 1), en8, NUM_DIGITS));
  assign nxt    = IDX_W'(next_enabled(3'(idx_q), en8, NUM_DIGITS));
  // Counter sits at 0 while idle and restarts at 0 on the idle exit.
  assign clr    = (digit_en == '0) || (state_q == IDLE);
  assign p_next = (clr || tc) ? '0 : cnt + 1'b1;

  sseg_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_presc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .en_i         (~clr),
    .cnt_o        (cnt),
    .tc_o         (tc),
    .blank_done_o (blank_done)
  );

`ifdef SSEG_DIM_EN
  logic [2:0] dim_q;
  logic       slot_start;

  // Brightness is latched once per slot so the drive window never changes
  // length partway through a digit.
  assign slot_start = (digit_en != '0) && ((state_q == IDLE) || tc);
  assign drive_end  = DE_W'(BLANK_CYCLES +
                            ((PRESCALE - BLANK_CYCLES) * (int'(dim_q) + 1)) / 8);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dim_q <= 3'd7;
    end else if (slot_start) begin
      dim_q <= dim_level;
    end
  end
`else
  assign drive_end = DE_W'(PRESCALE);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (digit_en == '0) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d  = BLANK;
      idx_d    = lowest;
      boundary = 1'b1;
    end else if (tc) begin
      state_d  = BLANK;
      idx_d    = nxt;
      boundary = (nxt == lowest);
    end else begin
      state_d = blank_done ? DRIVE : BLANK;
    end

    // Live digit_en gates the anode so a digit disabled mid-slot goes dark
    // right away while the slot itself runs to completion.
    anode_d = '1;
    if (state_d == DRIVE && digit_en[idx_d] && ({1'b0, p_next} < drive_end)) begin
      anode_d[idx_d] = 1'b0;
    end

    // Commit uses the shadow as it was before this cycle, so a load landing
    // on the boundary stays pending for the following frame.
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    if (boundary && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    if (load) begin
      shadow_d = load_data;
      pend_d   = 1'b1;
    end

    nibble_d = disp_d[{idx_d, 2'b00} +: NIBBLE_W];
    fs_d     = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      anode_q  <= '1;
      nibble_q <= '0;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      anode_q  <= anode_d;
      nibble_q <= nibble_d;
      ack_q    <= ack_d;
      fs_q     <= fs_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
    end
  end

  assign digit_idx   = idx_q;
  assign anode_n     = anode_q;
  assign nibble      = nibble_q;
  assign load_ack    = ack_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_scheduler.sv
// Directed bench for sseg_scan_scheduler with PRESCALE=8, BLANK_CYCLES=2,
// NUM_DIGITS=4. Expected outputs come from slot arithmetic on the cycle
// count since the scan was (re)started.
module tb_sseg_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit_en;
  logic        load;
  logic [15:0] load_data;
  logic        load_ack;
  logic [1:0]  digit_idx;
  logic [3:0]  anode_n;
  logic [3:0]  nibble;
  logic        frame_start;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sseg_scan_scheduler #(
    .NUM_DIGITS   (4),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
`ifdef SSEG_DIM_EN
    .dim_level   (3'd7),
`endif
    .rst_n       (rst_n),
    .digit_en    (digit_en),
    .load        (load),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .digit_idx   (digit_idx),
    .anode_n     (anode_n),
    .nibble      (nibble),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks cycles c0+1 .. c0+n after a scan start (cycle 1 is the first
  // posedge that sees digit_en nonzero while idle). The display value is
  // d_old before commit_c and d_new from commit_c on; load_ack is expected
  // only at commit_c (negative = no commit in this window).
  task automatic scan(input int c0, input int n, input logic [3:0] en,
                      input logic [15:0] d_old, input logic [15:0] d_new,
                      input int commit_c);
    int         order[$];
    int         slot, pos, k, idx;
    logic [3:0] ea;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) if (en[i]) order.push_back(i);
    for (int c = c0 + 1; c <= c0 + n; c++) begin
      @(negedge clk);
      slot = (c - 1) / 8;
      pos  = (c - 1) % 8;
      k    = slot % order.size();
      idx  = order[k];
      ea   = (pos < 2) ? 4'hF : ~(4'b0001 << idx);
      d    = (commit_c >= 0 && c >= commit_c) ? d_new : d_old;
      chk("digit_idx",   32'(digit_idx),   32'(idx));
      chk("anode_n",     32'(anode_n),     32'(ea));
      chk("frame_start", 32'(frame_start), 32'(pos == 0 && k == 0));
      chk("load_ack",    32'(load_ack),    32'(c == commit_c));
      chk("nibble",      32'(nibble),      32'(d[4*idx +: 4]));
    end
  endtask

  task automatic go_idle(input logic [1:0] held_idx);
    digit_en = 4'b0000;
    @(negedge clk);
    chk("idle_anode", 32'(anode_n), 32'hF);
    chk("idle_idx",   32'(digit_idx), 32'(held_idx));
    chk("idle_fs",    32'(frame_start), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    digit_en  = 4'b1111;
    load      = 1'b0;
    load_data = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_anode",  32'(anode_n),     32'hF);
    chk("rst_idx",    32'(digit_idx),   32'd0);
    chk("rst_nibble", 32'(nibble),      32'd0);
    chk("rst_ack",    32'(load_ack),    32'd0);
    chk("rst_fs",     32'(frame_start), 32'd0);

    // Full scan 0,1,2,3,0 ; stop while driving digit 0 (slot 4, pos 4)
    rst_n = 1'b1;
    scan(0, 37, 4'b1111, 16'h0, 16'h0, -1);
    go_idle(2'd0);
    @(negedge clk);
    chk("idle2_anode", 32'(anode_n), 32'hF);

    // Re-enable a single digit: every slot is a frame boundary
    digit_en = 4'b0100;
    scan(0, 20, 4'b0100, 16'h0, 16'h0, -1);
    go_idle(2'd2);

    // Alternating digits 1 and 3
    digit_en = 4'b1010;
    scan(0, 34, 4'b1010, 16'h0, 16'h0, -1);
    go_idle(2'd1);

    // Load mid-frame commits at the next boundary (cycle 33)
    digit_en = 4'b1111;
    scan(0, 12, 4'b1111, 16'h0, 16'h0, -1);
    load = 1'b1; load_data = 16'hABCD;
    scan(12, 1, 4'b1111, 16'h0, 16'h0, -1);
    load = 1'b0;
    scan(13, 52, 4'b1111, 16'h0, 16'hABCD, 33);

    // Two loads; the second lands on the boundary at cycle 97
    scan(65, 4, 4'b1111, 16'hABCD, 16'hABCD, -1);
    load = 1'b1; load_data = 16'h1111;
    scan(69, 1, 4'b1111, 16'hABCD, 16'hABCD, -1);
    load = 1'b0;
    scan(70, 26, 4'b1111, 16'hABCD, 16'hABCD, -1);
    load = 1'b1; load_data = 16'h2222;
    scan(96, 1, 4'b1111, 16'hABCD, 16'h1111, 97);
    load = 1'b0;
    scan(97, 37, 4'b1111, 16'h1111, 16'h2222, 129);

    // Reset pulse mid-drive with a load still pending
    load = 1'b1; load_data = 16'h5555;
    scan(134, 1, 4'b1111, 16'h2222, 16'h2222, -1);
    load  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_anode",  32'(anode_n),     32'hF);
    chk("rst2_idx",    32'(digit_idx),   32'd0);
    chk("rst2_nibble", 32'(nibble),      32'd0);
    chk("rst2_ack",    32'(load_ack),    32'd0);
    chk("rst2_fs",     32'(frame_start), 32'd0);
    rst_n = 1'b1;
    scan(0, 40, 4'b1111, 16'h0, 16'h0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
